// File: rtl/aes_selftest_seq.sv
// AES known-answer self-test sequencer.
// Walks a table of test vectors, launches the AES core once per enabled vector,
// compares each core result with the externally supplied expected block and
// keeps pass/fail/timeout tallies until the next run request or reset.
module aes_selftest_seq #(
    parameter int NUM_VECTORS    = 6,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 128,
    localparam int VI_W          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int CNT_W         = $clog2(NUM_VECTORS + 1),
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] vec_enable,
    output logic [VI_W-1:0]        vec_idx,
    input  logic [DATA_W-1:0]      vec_expected,
    output logic                   core_start,
    output logic [1:0]             core_mode,
    output logic                   core_decrypt,
    input  logic                   core_done,
    input  logic [DATA_W-1:0]      core_result,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pass_count,
    output logic [CNT_W-1:0]       fail_count,
    output logic                   all_pass,
    output logic                   timeout_flag,
    output logic [VI_W-1:0]        first_fail_idx,
    output logic                   first_fail_valid,
    output logic [7:0]             disp_byte
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_CHECK  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [VI_W-1:0]  LAST_IDX  = VI_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(NUM_VECTORS);
    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [VI_W-1:0]     vec_idx_q, vec_idx_d;
    logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic [VI_W-1:0]     ff_idx_q, ff_idx_d;
    logic                ff_vld_q, ff_vld_d;
    logic [7:0]          disp_q, disp_d;
    logic                core_start_q, core_start_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_ld;
    logic [1:0]          mode_raw;

    // Tallies stop at the vector count so they can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Key mode is the vector index shifted right by one, truncated to two bits.
    generate
        if (VI_W >= 3) begin : g_mode_wide
            assign mode_raw = vec_idx_q[2:1];
        end else if (VI_W == 2) begin : g_mode_two
            assign mode_raw = {1'b0, vec_idx_q[1]};
        end else begin : g_mode_one
            assign mode_raw = 2'b00;
        end
    endgenerate

    // Next-state, tally and capture logic for the whole sequence.
    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        wait_cnt_d   = wait_cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        ff_idx_d     = ff_idx_q;
        ff_vld_d     = ff_vld_q;
        disp_d       = disp_q;
        core_start_d = 1'b0;
        result_d     = result_q;
        result_ld    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A run request wipes every result of the previous run.
                if (start) begin
                    state_d    = S_SCAN;
                    vec_idx_d  = '0;
                    wait_cnt_d = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    timeout_d  = 1'b0;
                    ff_idx_d   = '0;
                    ff_vld_d   = 1'b0;
                    disp_d     = 8'h00;
                end
            end

            S_SCAN: begin
                // Disabled vectors pass straight through without touching tallies.
                if (vec_enable[vec_idx_q]) begin
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_NEXT;
                end
            end

            S_LAUNCH: begin
                core_start_d = 1'b1;
                wait_cnt_d   = '0;
                state_d      = S_WAIT;
            end

            S_WAIT: begin
                // A completion in the last allowed cycle still counts as a completion.
                if (core_done) begin
                    result_d  = core_result;
                    result_ld = 1'b1;
                    disp_d    = core_result[7:0];
                    state_d   = S_CHECK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fail_d    = sat_inc(fail_q);
                    timeout_d = 1'b1;
                    if (!ff_vld_q) begin
                        ff_idx_d = vec_idx_q;
                        ff_vld_d = 1'b1;
                    end
                    state_d   = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end

            S_CHECK: begin
                if (result_q == vec_expected) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    if (!ff_vld_q) begin
                        ff_idx_d = vec_idx_q;
                        ff_vld_d = 1'b1;
                    end
                end
                state_d = S_NEXT;
            end

            S_NEXT: begin
                // The index parks on the last vector rather than wrapping.
                if (vec_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + VI_W'(1);
                    state_d   = S_SCAN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers; reset returns everything to the idle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vec_idx_q    <= '0;
            wait_cnt_q   <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            timeout_q    <= 1'b0;
            ff_idx_q     <= '0;
            ff_vld_q     <= 1'b0;
            disp_q       <= 8'h00;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            ff_idx_q     <= ff_idx_d;
            ff_vld_q     <= ff_vld_d;
            disp_q       <= disp_d;
            core_start_q <= core_start_d;
        end
    end

    // Captured core block; only read in CHECK after a load, so it needs no reset.
    always_ff @(posedge clk) begin
        if (result_ld) begin
            result_q <= result_d;
        end
    end

    assign vec_idx          = vec_idx_q;
    assign core_start       = core_start_q;
    assign core_mode        = reset ? 2'b00 : mode_raw;
    assign core_decrypt     = reset ? 1'b0 : vec_idx_q[0];
    assign busy             = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                              (state_q == S_CHECK)  || (state_q == S_NEXT);
    assign done             = (state_q == S_DONE);
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign all_pass         = (state_q == S_DONE) && (fail_q == '0) && (pass_q != '0);
    assign timeout_flag     = timeout_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_valid = ff_vld_q;
    assign disp_byte        = disp_q;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Directed bench for the AES self-test sequencer with a behavioural core model.
module tb_aes_selftest_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   vec_enable;
    logic [2:0]   vec_idx;
    logic [127:0] vec_expected;
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_decrypt;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;
    logic         done;
    logic [2:0]   pass_count;
    logic [2:0]   fail_count;
    logic         all_pass;
    logic         timeout_flag;
    logic [2:0]   first_fail_idx;
    logic         first_fail_valid;
    logic [7:0]   disp_byte;

    int passed = 0;
    int total  = 0;

    // Known-answer table, blocks packed with FIPS-197 byte 0 in bits [7:0].
    logic [127:0] exp_tbl [0:7];
    logic         stale_done = 1'b0;

    // Core model state.
    logic         model_done   = 1'b0;
    logic [127:0] model_result = '0;
    logic         pend         = 1'b0;
    int           cnt          = 0;
    logic [2:0]   m_idx        = '0;
    int           cyc          = 0;
    int           starts       = 0;
    int           doubles      = 0;
    logic         prev_cs      = 1'b0;
    int           start_cyc [0:7];
    int           hang_vec     = -1;
    logic [7:0]   corrupt      = '0;

    assign vec_expected = exp_tbl[vec_idx];
    assign core_done    = model_done | stale_done;
    assign core_result  = stale_done ? {16{8'hAA}} : model_result;

    aes_selftest_seq #(
        .NUM_VECTORS   (6),
        .TIMEOUT_CYCLES(64),
        .DATA_W        (128)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .vec_enable      (vec_enable),
        .vec_idx         (vec_idx),
        .vec_expected    (vec_expected),
        .core_start      (core_start),
        .core_mode       (core_mode),
        .core_decrypt    (core_decrypt),
        .core_done       (core_done),
        .core_result     (core_result),
        .busy            (busy),
        .done            (done),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .all_pass        (all_pass),
        .timeout_flag    (timeout_flag),
        .first_fail_idx  (first_fail_idx),
        .first_fail_valid(first_fail_valid),
        .disp_byte       (disp_byte)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] brev(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = x[(15-b)*8 +: 8];
        return r;
    endfunction

    // Core model: done arrives 11/13/15 cycles after the launch pulse by key mode.
    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_cs    <= core_start;
        model_done <= 1'b0;
        if (core_start && prev_cs) doubles <= doubles + 1;
        if (pend) begin
            if (cnt == 1) begin
                pend         <= 1'b0;
                model_done   <= 1'b1;
                model_result <= exp_tbl[m_idx] ^ {127'b0, corrupt[m_idx]};
            end
            cnt <= cnt - 1;
        end
        if (core_start) begin
            starts             <= starts + 1;
            start_cyc[vec_idx] <= cyc;
            if (int'(vec_idx) != hang_vec) begin
                pend  <= 1'b1;
                cnt   <= 11 + 2 * int'(vec_idx >> 1);
                m_idx <= vec_idx;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 1);
    endtask

    initial begin
        int s0;
        int d0;
        logic found;
        logic [127:0] pt;
        logic [127:0] ct [0:2];

        pt    = 128'h00112233445566778899aabbccddeeff;
        ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) exp_tbl[i] = brev((i % 2 == 1) ? pt : ct[i / 2]);
            else       exp_tbl[i] = '0;
        end
        for (int i = 0; i < 8; i++) start_cyc[i] = 0;

        reset      = 1'b1;
        start      = 1'b0;
        vec_enable = 6'h3f;
        repeat (3) tick();

        // Reset state
        check("rst_vec_idx",  32'(vec_idx), 0);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_pass",     32'(pass_count), 0);
        check("rst_fail",     32'(fail_count), 0);
        check("rst_all_pass", 32'(all_pass), 0);
        check("rst_timeout",  32'(timeout_flag), 0);
        check("rst_ff_idx",   32'(first_fail_idx), 0);
        check("rst_ff_vld",   32'(first_fail_valid), 0);
        check("rst_disp",     32'(disp_byte), 0);
        check("rst_mode",     32'(core_mode), 0);
        check("rst_decrypt",  32'(core_decrypt), 0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);

        // All six vectors enabled, start pulsed again mid-run
        s0 = starts;
        d0 = doubles;
        pulse_start();
        check("t1_first_idx", 32'(vec_idx), 0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (vec_idx == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("t1_reach_idx2", 32'(found), 1);
        pulse_start();
        wait_done("t1_done", 500);
        check("t1_pass",     32'(pass_count), 6);
        check("t1_fail",     32'(fail_count), 0);
        check("t1_all_pass", 32'(all_pass), 1);
        check("t1_disp",     32'(disp_byte), 8'h00);
        check("t1_timeout",  32'(timeout_flag), 0);
        check("t1_ff_vld",   32'(first_fail_valid), 0);
        check("t1_starts",   32'(starts - s0), 6);
        check("t1_pulse_w",  32'(doubles - d0), 0);
        check("t1_lat_m0",   32'(start_cyc[1] - start_cyc[0]), 16);
        check("t1_lat_m1",   32'(start_cyc[3] - start_cyc[2]), 18);
        check("t1_last_idx", 32'(vec_idx), 5);
        check("t1_busy",     32'(busy), 0);
        repeat (5) tick();
        check("t1_hold_done", 32'(done), 1);
        check("t1_hold_pass", 32'(pass_count), 6);
        stale_done = 1'b1;
        tick();
        stale_done = 1'b0;
        tick();
        check("t1_stale_disp", 32'(disp_byte), 8'h00);
        check("t1_stale_pass", 32'(pass_count), 6);
        check("t1_stale_done", 32'(done), 1);

        // Vectors 3 and 5 corrupted: first failure stays at 3
        corrupt = 8'h28;
        pulse_start();
        wait_done("t2a_done", 500);
        check("t2a_pass",   32'(pass_count), 4);
        check("t2a_fail",   32'(fail_count), 2);
        check("t2a_ff_idx", 32'(first_fail_idx), 3);
        check("t2a_ff_vld", 32'(first_fail_valid), 1);
        check("t2a_all",    32'(all_pass), 0);
        check("t2a_disp",   32'(disp_byte), 8'h01);

        // Vector 3 LSB corrupted only
        corrupt = 8'h08;
        pulse_start();
        check("t2_clr_disp", 32'(disp_byte), 0);
        check("t2_clr_fail", 32'(fail_count), 0);
        check("t2_clr_ffv",  32'(first_fail_valid), 0);
        wait_done("t2_done", 500);
        check("t2_pass",   32'(pass_count), 5);
        check("t2_fail",   32'(fail_count), 1);
        check("t2_ff_idx", 32'(first_fail_idx), 3);
        check("t2_ff_vld", 32'(first_fail_valid), 1);
        check("t2_all",    32'(all_pass), 0);

        // Core hangs on vector 4
        corrupt  = 8'h00;
        hang_vec = 4;
        s0 = starts;
        pulse_start();
        wait_done("t3_done", 600);
        check("t3_timeout", 32'(timeout_flag), 1);
        check("t3_fail",    32'(fail_count), 1);
        check("t3_pass",    32'(pass_count), 5);
        check("t3_ff_idx",  32'(first_fail_idx), 4);
        check("t3_wait_len", 32'(start_cyc[5] - start_cyc[4]), 67);
        check("t3_starts",  32'(starts - s0), 6);
        check("t3_all",     32'(all_pass), 0);
        hang_vec = -1;

        // Only vector 0 enabled
        vec_enable = 6'b000001;
        s0 = starts;
        pulse_start();
        wait_done("t4_done", 300);
        check("t4_starts", 32'(starts - s0), 1);
        check("t4_pass",   32'(pass_count), 1);
        check("t4_fail",   32'(fail_count), 0);
        check("t4_all",    32'(all_pass), 1);
        check("t4_timeout", 32'(timeout_flag), 0);

        // Nothing enabled
        vec_enable = 6'b000000;
        s0 = starts;
        pulse_start();
        wait_done("t5_done", 100);
        check("t5_all",    32'(all_pass), 0);
        check("t5_pass",   32'(pass_count), 0);
        check("t5_fail",   32'(fail_count), 0);
        check("t5_starts", 32'(starts - s0), 0);

        // Reset in the middle of vector 2, with start held alongside it
        vec_enable = 6'h3f;
        corrupt    = 8'h02;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (vec_idx == 3'd2 && core_start) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach_wait", 32'(found), 1);
        repeat (3) tick();
        check("t6_pre_busy", 32'(busy), 1);
        check("t6_pre_disp", 32'(disp_byte), 8'h01);
        check("t6_pre_fail", 32'(fail_count), 1);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check("t6_mode_in_rst", 32'(core_mode), 0);
        tick();
        tick();
        check("t6_rst_idx",   32'(vec_idx), 0);
        check("t6_rst_busy",  32'(busy), 0);
        check("t6_rst_done",  32'(done), 0);
        check("t6_rst_pass",  32'(pass_count), 0);
        check("t6_rst_fail",  32'(fail_count), 0);
        check("t6_rst_ffv",   32'(first_fail_valid), 0);
        check("t6_rst_disp",  32'(disp_byte), 0);
        check("t6_rst_cs",    32'(core_start), 0);
        reset   = 1'b0;
        start   = 1'b0;
        corrupt = 8'h00;
        repeat (20) tick();
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_done", 32'(done), 0);
        check("t6_idle_disp", 32'(disp_byte), 0);
        check("t6_idle_pass", 32'(pass_count), 0);
        check("t6_idle_fail", 32'(fail_count), 0);
        pulse_start();
        check("t6_new_idx",  32'(vec_idx), 0);
        check("t6_new_done", 32'(done), 0);
        wait_done("t6_done", 500);
        check("t6_pass", 32'(pass_count), 6);
        check("t6_fail", 32'(fail_count), 0);
        check("t6_all",  32'(all_pass), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
